// File: rtl/ysyx_22041211_rf_pkg.sv
// Shared sizing defaults and helpers for the regfile/scoreboard slice.
package ysyx_22041211_rf_pkg;

    localparam int unsigned DEF_NR_REGS    = 16;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_NR_RD      = 2;

    // Index of the hardwired-zero register.
    localparam int unsigned ZERO_REG = 0;

    // Register address width; a one-register file still needs a 1-bit address.
    function automatic int unsigned calc_aw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ysyx_22041211_scoreboard.sv
// Per-register busy scoreboard: tracks pending writes, detects RAW/WAW
// hazards and produces issue_ready.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rd_addr, rd_use          packed read addresses and their use flags
//   issue_valid/wen/rd       instruction being issued
//   wb_valid, wb_rd          write-back strobe and destination
//   flush                    drop every pending write
//   issue_ready              combinational issue permission
//   busy_vec                 registered busy bits
module ysyx_22041211_scoreboard
    import ysyx_22041211_rf_pkg::*;
#(
    parameter int unsigned NR_REGS = DEF_NR_REGS,
    parameter int unsigned NR_RD   = DEF_NR_RD,
    parameter int unsigned AW      = calc_aw(NR_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NR_RD*AW-1:0]   rd_addr,
    input  logic [NR_RD-1:0]      rd_use,
    input  logic                  issue_valid,
    input  logic                  issue_wen,
    input  logic [AW-1:0]         issue_rd,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_rd,
    input  logic                  flush,
    output logic                  issue_ready,
    output logic [NR_REGS-1:0]    busy_vec
);

    logic [NR_REGS-1:0] busy_q;
    logic [NR_REGS-1:0] busy_d;
    logic [NR_RD-1:0]   port_haz_c;
    logic               waw_haz_c;
    logic               issue_fire_c;

    // Per-port RAW hazard; a write-back to the same register resolves it this cycle.
    for (genvar g = 0; g < NR_RD; g++) begin : g_port_haz
        logic [AW-1:0] addr_c;
        assign addr_c        = rd_addr[g*AW +: AW];
        assign port_haz_c[g] = rd_use[g] && busy_q[addr_c]
                               && !(wb_valid && (wb_rd == addr_c));
    end

    // Hazard combination and issue permission; independent of issue_valid.
    always_comb begin
        waw_haz_c    = issue_wen && (issue_rd != AW'(ZERO_REG)) && busy_q[issue_rd]
                       && !(wb_valid && (wb_rd == issue_rd));
        issue_ready  = !((|port_haz_c) || waw_haz_c || flush || rst);
        issue_fire_c = issue_valid && issue_ready;
    end

    // Busy next state: flush beats write-back clear, a new issue beats both.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else if (wb_valid && (wb_rd != AW'(ZERO_REG))) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (issue_fire_c && issue_wen && (issue_rd != AW'(ZERO_REG))) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/ysyx_22041211_regfile_sb.sv
// Multi-read-port integer register file with write-back bypass and busy
// scoreboard.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rd_addr, rd_use          packed read addresses / operand-needed flags
//   rd_data                  packed combinational read data
//   issue_valid/wen/rd       issuing instruction, issue_ready back
//   wb_valid/rd/data         write-back strobe
//   flush                    squash all pending writes
//   busy_vec                 scoreboard state
module ysyx_22041211_regfile_sb
    import ysyx_22041211_rf_pkg::*;
#(
    parameter int unsigned NR_REGS    = DEF_NR_REGS,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NR_RD      = DEF_NR_RD
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NR_RD*calc_aw(NR_REGS)-1:0]       rd_addr,
    input  logic [NR_RD-1:0]                        rd_use,
    output logic [NR_RD*DATA_WIDTH-1:0]             rd_data,
    input  logic                                    issue_valid,
    input  logic                                    issue_wen,
    input  logic [calc_aw(NR_REGS)-1:0]             issue_rd,
    output logic                                    issue_ready,
    input  logic                                    wb_valid,
    input  logic [calc_aw(NR_REGS)-1:0]             wb_rd,
    input  logic [DATA_WIDTH-1:0]                   wb_data,
    input  logic                                    flush,
    output logic [NR_REGS-1:0]                      busy_vec
);

    localparam int unsigned AW = calc_aw(NR_REGS);

    logic [DATA_WIDTH-1:0] mem_q [NR_REGS];
    logic [DATA_WIDTH-1:0] mem_d [NR_REGS];
    logic                  wb_we_c;

    // Write path; x0 writes are dropped. Flush does not block data writes.
    always_comb begin
        mem_d   = mem_q;
        wb_we_c = wb_valid && (wb_rd != AW'(ZERO_REG));
        if (wb_we_c) begin
            mem_d[wb_rd] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NR_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read ports: x0 reads zero, then same-cycle write-back bypass, then array.
    for (genvar g = 0; g < NR_RD; g++) begin : g_rd_port
        logic [AW-1:0] addr_c;
        assign addr_c = rd_addr[g*AW +: AW];
        assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] =
            (addr_c == AW'(ZERO_REG))          ? '0      :
            (wb_valid && (wb_rd == addr_c))    ? wb_data :
                                                 mem_q[addr_c];
    end

    ysyx_22041211_scoreboard #(
        .NR_REGS (NR_REGS),
        .NR_RD   (NR_RD),
        .AW      (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_use      (rd_use),
        .issue_valid (issue_valid),
        .issue_wen   (issue_wen),
        .issue_rd    (issue_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .flush       (flush),
        .issue_ready (issue_ready),
        .busy_vec    (busy_vec)
    );

endmodule

// File: tb/tb_ysyx_22041211_regfile_sb.sv
// Bench for ysyx_22041211_regfile_sb (3 read ports): directed scenarios with
// literal expectations plus an every-cycle comparison against a behavioural model.
module tb_ysyx_22041211_regfile_sb;

    localparam int NR  = 16;
    localparam int DW  = 32;
    localparam int NRD = 3;
    localparam int AW  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD-1:0]    rd_use;
    logic [NRD*DW-1:0] rd_data;
    logic              issue_valid;
    logic              issue_wen;
    logic [AW-1:0]     issue_rd;
    logic              issue_ready;
    logic              wb_valid;
    logic [AW-1:0]     wb_rd;
    logic [DW-1:0]     wb_data;
    logic              flush;
    logic [NR-1:0]     busy_vec;

    ysyx_22041211_regfile_sb #(
        .NR_REGS    (NR),
        .DATA_WIDTH (DW),
        .NR_RD      (NRD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_use      (rd_use),
        .rd_data     (rd_data),
        .issue_valid (issue_valid),
        .issue_wen   (issue_wen),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flush       (flush),
        .busy_vec    (busy_vec)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: plain arrays of register values and pending flags.
    int unsigned m_val  [NR];
    bit          m_busy [NR];

    initial begin
        for (int r = 0; r < NR; r++) begin
            m_val[r]  = 0;
            m_busy[r] = 0;
        end
    end

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    endtask

    function automatic int port_addr(input int p);
        logic [NRD*AW-1:0] a;
        a = rd_addr;
        return int'(a[p*AW +: AW]);
    endfunction

    function automatic bit wb_hits(input int r);
        return wb_valid && (int'(wb_rd) == r);
    endfunction

    function automatic int unsigned model_rd(input int p);
        int a;
        a = port_addr(p);
        if (a == 0) return 0;
        if (wb_hits(a)) return wb_data;
        return m_val[a];
    endfunction

    function automatic bit model_ready();
        int a;
        if (rst || flush) return 0;
        for (int p = 0; p < NRD; p++) begin
            a = port_addr(p);
            if (rd_use[p] && m_busy[a] && !wb_hits(a)) return 0;
        end
        if (issue_wen && issue_rd != 0 && m_busy[issue_rd] && !wb_hits(int'(issue_rd))) return 0;
        return 1;
    endfunction

    function automatic logic [NR-1:0] model_busy_vec();
        logic [NR-1:0] v;
        for (int r = 0; r < NR; r++) v[r] = m_busy[r];
        return v;
    endfunction

    // Model state advance on each rising edge.
    always @(posedge clk) begin
        bit fire;
        fire = issue_valid && model_ready();
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_val[r]  = 0;
                m_busy[r] = 0;
            end
        end else begin
            if (wb_valid && wb_rd != 0) begin
                m_val[wb_rd]  = wb_data;
                m_busy[wb_rd] = 0;
            end
            if (flush) for (int r = 0; r < NR; r++) m_busy[r] = 0;
            if (fire && issue_wen && issue_rd != 0) m_busy[issue_rd] = 1;
        end
    end

    // Every-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < NRD; p++)
                check($sformatf("model rd_data[%0d]", p), rd_data[p*DW +: DW], model_rd(p));
            check("model issue_ready", DW'(issue_ready), DW'(model_ready()));
            check("model busy_vec", DW'(busy_vec), DW'(model_busy_vec()));
        end
    end

    task automatic idle();
        issue_valid = 0; issue_wen = 0; issue_rd = '0;
        wb_valid = 0; wb_rd = '0; wb_data = '0;
        flush = 0; rd_use = '0;
    endtask

    task automatic set_port(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    function automatic logic [DW-1:0] port(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    initial begin
        rst = 1; rd_addr = '0; idle();
        next();
        chk_en = 1;

        // Reset test: preload x5, mark it busy, then reset.
        rst = 0; wb_valid = 1; wb_rd = 5; wb_data = 32'h1234; set_port(0, 5);
        @(negedge clk); check("preload bypass x5", port(0), 32'h1234);
        next(); idle(); issue_valid = 1; issue_wen = 1; issue_rd = 5;
        @(negedge clk); check("x5 array", port(0), 32'h1234);
        next(); idle(); rst = 1;
        @(negedge clk); check("ready low in rst", DW'(issue_ready), 0);
        next(); rst = 0;
        @(negedge clk);
        check("x5 after rst", port(0), 0);
        check("busy after rst", DW'(busy_vec), 0);
        check("ready after rst", DW'(issue_ready), 1);

        // Zero register.
        next(); wb_valid = 1; wb_rd = 0; wb_data = 32'hFFFF_FFFF;
        issue_valid = 1; issue_wen = 1; issue_rd = 0; set_port(0, 0);
        @(negedge clk); check("x0 read during wb", port(0), 0);
        next(); idle();
        @(negedge clk);
        check("x0 read after wb", port(0), 0);
        check("x0 never busy", DW'(busy_vec), 0);

        // RAW stall and bypass.
        next(); issue_valid = 1; issue_wen = 1; issue_rd = 3;
        next(); issue_wen = 0; issue_rd = 0; rd_use = 3'b001; set_port(0, 3);
        @(negedge clk);
        check("x3 busy", DW'(busy_vec), 32'h0008);
        check("RAW stall", DW'(issue_ready), 0);
        next(); wb_valid = 1; wb_rd = 3; wb_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("RAW released by wb", DW'(issue_ready), 1);
        check("RAW bypass data", port(0), 32'hDEAD_BEEF);
        next(); idle();
        @(negedge clk);
        check("x3 busy cleared", DW'(busy_vec), 0);
        check("x3 array", port(0), 32'hDEAD_BEEF);

        // WAW stall, then same-cycle issue and wb.
        next(); issue_valid = 1; issue_wen = 1; issue_rd = 7;
        next();
        @(negedge clk);
        check("WAW busy x7", DW'(busy_vec), 32'h0080);
        check("WAW stall", DW'(issue_ready), 0);
        next(); wb_valid = 1; wb_rd = 7; wb_data = 32'h55;
        @(negedge clk); check("WAW released by wb", DW'(issue_ready), 1);
        next(); idle(); set_port(0, 7);
        @(negedge clk);
        check("x7 stays busy", DW'(busy_vec), 32'h0080);
        check("x7 data written", port(0), 32'h55);

        // Flush: x9 gets a value, then x2, x9, x15 busy.
        next(); wb_valid = 1; wb_rd = 9; wb_data = 32'h99;
        issue_valid = 1; issue_wen = 1; issue_rd = 2;
        next(); idle(); issue_valid = 1; issue_wen = 1; issue_rd = 9;
        next(); issue_rd = 15;
        next(); idle(); flush = 1; wb_valid = 1; wb_rd = 2; wb_data = 32'h77;
        issue_valid = 1; issue_wen = 1; issue_rd = 4;
        @(negedge clk);
        check("flush blocks issue", DW'(issue_ready), 0);
        check("busy before flush", DW'(busy_vec), 32'h8284);
        next(); idle(); set_port(0, 2); set_port(1, 9);
        @(negedge clk);
        check("busy after flush", DW'(busy_vec), 0);
        check("x2 after flush", port(0), 32'h77);
        check("x9 kept", port(1), 32'h99);

        // Multi-port bypass, wb to a non-busy register.
        next(); wb_valid = 1; wb_rd = 4; wb_data = 32'h44;
        next(); wb_rd = 1; wb_data = 32'hA; set_port(0, 1); set_port(1, 1); set_port(2, 4);
        @(negedge clk);
        check("port0 bypass x1", port(0), 32'hA);
        check("port1 bypass x1", port(1), 32'hA);
        check("port2 array x4", port(2), 32'h44);

        // Pseudo-random traffic over a narrow register range, model-checked.
        for (int n = 0; n < 400; n++) begin
            next();
            rst         = ($urandom_range(0, 59) == 0);
            flush       = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < NRD; p++) set_port(p, $urandom_range(0, 7));
            rd_use      = NRD'($urandom_range(0, 7));
            issue_valid = $urandom_range(0, 1) == 1;
            issue_wen   = $urandom_range(0, 3) != 0;
            issue_rd    = AW'($urandom_range(0, 7));
            wb_valid    = $urandom_range(0, 2) == 0;
            wb_rd       = AW'($urandom_range(0, 7));
            wb_data     = $urandom;
        end

        next(); rst = 0; idle();
        @(negedge clk);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22041211_regfile_sb.md
# ysyx_22041211_regfile_sb

Parametrised multi-read-port integer register file with write-back bypass and a per-register busy scoreboard. It sits between decode/issue and write-back in the ysyx_22041211 core. It accepts an instruction's source/destination registers at issue and stalls it while any needed register has a write pending. It drops the pending mark when write-back arrives, and supplies forwarded operands in the same cycle.

## Interface
Parameters:
- NR_REGS, 16, number of architectural registers (power of two ≥ 2); AW = $clog2(NR_REGS)
- DATA_WIDTH, 32, register width
- NR_RD, 2, number of read ports (≥ 1)

Ports:
- clk  in  1  sole clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NR_RD*AW  packed read addresses; port i at [i*AW +: AW]
- rd_use  in  NR_RD  port i operand is needed by the issuing instruction
- rd_data  out  NR_RD*DATA_WIDTH  packed read data, combinational
- issue_valid  in  1  decode presents an instruction
- issue_wen  in  1  instruction writes a destination
- issue_rd  in  AW  destination register
- issue_ready  out  1  instruction may issue this cycle
- wb_valid  in  1  write-back strobe
- wb_rd  in  AW  write-back register
- wb_data  in  DATA_WIDTH  write-back data
- flush  in  1  discard all pending writes (pipeline squash)
- busy_vec  out  NR_REGS  scoreboard state, bit r = register r pending

## Operation
- Storage: NR_REGS × DATA_WIDTH array plus busy[NR_REGS-1:0].
- Register 0 is hardwired:
  - reads return 0
  - writes are discarded
  - busy[0] is never set
- Read port i:
  - rd_addr_i == 0 → 0
  - else if wb_valid && wb_rd == rd_addr_i → wb_data (bypass)
  - else → array[rd_addr_i]
- Hazard for port i: rd_use[i] && busy[rd_addr_i] && !(wb_valid && wb_rd == rd_addr_i).
- WAW hazard: issue_wen && issue_rd != 0 && busy[issue_rd] && !(wb_valid && wb_rd == issue_rd).
- issue_ready is 1 only when all of these hold:
  - no read-port hazard
  - no WAW hazard
  - !flush
  - !rst
- Issue fires on issue_valid && issue_ready. If issue_wen && issue_rd != 0, set busy[issue_rd].
- Write-back (wb_valid, wb_rd != 0):
  - writes array[wb_rd] <= wb_data
  - clears busy[wb_rd]
  - a write-back to a non-busy register is legal; it writes data and busy stays 0
- Simultaneous issue and wb to the same rd: issue wins, busy[rd] remains 1 (new producer pending); the data write still occurs.
- flush: clears all busy bits next cycle; array contents are untouched. A wb in the same cycle still writes data. Issue is blocked (issue_ready = 0).
- rst: all array entries ← 0, busy ← 0 in one cycle. rst overrides wb, issue and flush.

## Timing
- Read: zero latency (combinational from rd_addr, wb_*, array).
- Write and busy update: visible to non-bypassed reads and to busy_vec the cycle after the strobe.
- Bypass and hazard clear: same cycle as wb_valid. An instruction waiting on register r issues in the wb cycle for r.
- issue_ready is combinational from rd_addr, rd_use, issue_wen, issue_rd, wb_*, busy, flush, rst. It must not depend on issue_valid.
- Reset values, cycle after rst:
  - busy_vec = 0
  - issue_ready = 1 (when rst low and no flush)
  - rd_data = 0 for any address with wb_valid low
- Reset mid-operation: pending busy bits and in-flight wb are lost; the register state after reset is all-zero.

## Structure
- Package ysyx_22041211_rf_pkg holds:
  - default NR_REGS and DATA_WIDTH
  - the AW derivation function
  - the zero-register index constant
- Sub-module ysyx_22041211_scoreboard owns busy[], the issue/wb/flush/rst update priority and the hazard/issue_ready logic. The top holds the array, the write path and the per-port bypass muxes (generate loop over NR_RD).

## Test plan
- Reset: preload x5 = 0x1234, assert rst 1 cycle → read x5 = 0, busy_vec = 0, issue_ready = 1.
- Zero reg: wb x0 = 0xFFFF_FFFF, issue with issue_rd = 0 → reads of x0 = 0, busy_vec[0] stays 0.
- RAW stall + bypass:
  - issue with issue_rd = 3 → busy_vec[3] = 1
  - next instruction with rd_use[0], rd_addr0 = 3 → issue_ready = 0
  - assert wb x3 = 0xDEAD_BEEF → same cycle issue_ready = 1, rd_data0 = 0xDEAD_BEEF
  - next cycle busy_vec[3] = 0
- WAW and same-cycle issue/wb:
  - busy x7; issue to x7 with no wb → stall
  - issue to x7 together with wb x7 = 0x55 → issue accepted, busy_vec[7] = 1, array x7 = 0x55
- Flush: set busy on x2, x9, x15; pulse flush with wb x2 = 0x77 →
  - issue_ready = 0 that cycle
  - next cycle busy_vec = 0, x2 reads 0x77
  - x9 keeps its old value
- Multi-port (NR_RD = 3): ports read x1, x1, x4 while wb x1 = 0xA → ports 0 and 1 return 0xA, port 2 returns array x4.
